// File: rtl/ge_threshold_monitor_pkg.sv
// Shared definitions for the threshold monitor: FSM state encoding,
// default parameter values and the sample counter saturation limit.
package ge_threshold_monitor_pkg;

  typedef enum logic [1:0] {
    BELOW   = 2'd0,
    RISING  = 2'd1,
    ALARM   = 2'd2,
    FALLING = 2'd3
  } state_t;

  localparam int          DEBOUNCE_DEF   = 4;
  localparam logic [7:0]  THRESH_RST_DEF = 8'h80;
  localparam logic [15:0] SAMPLE_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/eight_bit_comp.sv
// Unsigned 8-bit magnitude comparator: exactly one of g (a>b), q (a==b),
// l (a<b) is high.
module eight_bit_comp (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       g,
  output logic       q,
  output logic       l
);

  assign g = (a > b);
  assign q = (a == b);
  assign l = (a < b);

endmodule

// File: rtl/ge_threshold_monitor.sv
// Registers a sample stream, compares it against a programmable threshold and
// drives a debounced >= alarm plus running max / count statistics.
module ge_threshold_monitor
  import ge_threshold_monitor_pkg::*;
#(
  parameter int         DEBOUNCE   = DEBOUNCE_DEF,
  parameter logic [7:0] THRESH_RST = THRESH_RST_DEF,
  parameter int         CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        thresh_wr,
  input  logic [7:0]  thresh_in,
  input  logic        clear_stats,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        ge_flag,
  output logic        alarm,
  output logic        alarm_rise,
  output logic        alarm_fall,
  output logic [7:0]  max_val,
  output logic [15:0] sample_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);

  logic [7:0]       thresh_q;
  logic [7:0]       sample_q;
  logic             valid_q;
  logic             xfer;
  logic             thr_g, thr_q, thr_l;
  logic             max_g;
  logic             unused_max_eq, unused_max_lt;
  logic             ge, lt, gt;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // A threshold write steals the cycle so the source keeps its sample.
  assign s_ready = ~reset & ~thresh_wr;
  assign xfer    = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      thresh_q <= THRESH_RST;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (thresh_wr) thresh_q <= thresh_in;
      if (xfer) sample_q <= s_data;
      valid_q <= xfer;
    end
  end

  eight_bit_comp u_thresh_comp (
    .a (sample_q),
    .b (thresh_q),
    .g (thr_g),
    .q (thr_q),
    .l (thr_l)
  );

  eight_bit_comp u_max_comp (
    .a (sample_q),
    .b (max_val),
    .g (max_g),
    .q (unused_max_eq),
    .l (unused_max_lt)
  );

  assign ge      = thr_g | thr_q;
  assign lt      = thr_l;
  assign gt      = max_g;
  assign ge_flag = valid_q & ge;

  // Hysteresis FSM: only valid samples move it, so idle gaps keep a run alive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BELOW;
      cnt        <= '0;
      alarm      <= 1'b0;
      alarm_rise <= 1'b0;
      alarm_fall <= 1'b0;
    end else begin
      alarm_rise <= 1'b0;
      alarm_fall <= 1'b0;
      if (valid_q) begin
        case (state)
          BELOW: begin
            if (ge) begin
              if (DEBOUNCE == 1) begin
                state      <= ALARM;
                cnt        <= '0;
                alarm      <= 1'b1;
                alarm_rise <= 1'b1;
              end else begin
                state <= RISING;
                cnt   <= CNT_ONE;
              end
            end else begin
              cnt <= '0;
            end
          end
          RISING: begin
            if (ge) begin
              if (cnt == DB_LAST) begin
                state      <= ALARM;
                cnt        <= '0;
                alarm      <= 1'b1;
                alarm_rise <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else begin
              state <= BELOW;
              cnt   <= '0;
            end
          end
          ALARM: begin
            if (lt) begin
              if (DEBOUNCE == 1) begin
                state      <= BELOW;
                cnt        <= '0;
                alarm      <= 1'b0;
                alarm_fall <= 1'b1;
              end else begin
                state <= FALLING;
                cnt   <= CNT_ONE;
              end
            end
          end
          FALLING: begin
            if (lt) begin
              if (cnt == DB_LAST) begin
                state      <= BELOW;
                cnt        <= '0;
                alarm      <= 1'b0;
                alarm_fall <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else begin
              state <= ALARM;
              cnt   <= '0;
            end
          end
          default: begin
            state <= BELOW;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // A clear that coincides with a valid sample restarts the stats from that sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_val    <= '0;
      sample_cnt <= '0;
    end else if (clear_stats) begin
      if (valid_q) begin
        max_val    <= sample_q;
        sample_cnt <= 16'd1;
      end else begin
        max_val    <= '0;
        sample_cnt <= '0;
      end
    end else if (valid_q) begin
      if (sample_cnt != SAMPLE_CNT_MAX) sample_cnt <= sample_cnt + 16'd1;
      if (gt) max_val <= sample_q;
    end
  end

endmodule

// File: tb/tb_ge_threshold_monitor.sv
// Directed bench for ge_threshold_monitor: ge_flag is scoreboarded per accepted
// sample, alarm/statistics are checked against hand-computed values.
module tb_ge_threshold_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        thresh_wr;
  logic [7:0]  thresh_in;
  logic        clear_stats;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        ge_flag;
  logic        alarm;
  logic        alarm_rise;
  logic        alarm_fall;
  logic [7:0]  max_val;
  logic [15:0] sample_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];
  logic acc_d = 1'b0;

  ge_threshold_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .thresh_wr   (thresh_wr),
    .thresh_in   (thresh_in),
    .clear_stats (clear_stats),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .ge_flag     (ge_flag),
    .alarm       (alarm),
    .alarm_rise  (alarm_rise),
    .alarm_fall  (alarm_fall),
    .max_val     (max_val),
    .sample_cnt  (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic exp_ge);
    s_valid = 1'b1;
    s_data  = data;
    exp_q.push_back(exp_ge);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Transfer tracking from the bench's own view of the handshake
  always @(posedge clk) acc_d <= s_valid & ~reset & ~thresh_wr;

  always @(negedge clk) begin
    if (acc_d) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected", 16'd1, 16'd0);
      end else begin
        checkOutput("sb_ge_flag", {15'd0, ge_flag}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rise_data[5];
    logic       rise_ge[5];
    logic [7:0] fall_data[8];
    logic       fall_ge[8];
    rise_data = '{8'h7F, 8'h80, 8'h80, 8'h80, 8'h80};
    rise_ge   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    fall_data = '{8'h10, 8'h10, 8'h10, 8'hFF, 8'h10, 8'h10, 8'h10, 8'h10};
    fall_ge   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; thresh_wr = 1'b0; thresh_in = 8'h00;
    clear_stats = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    idle(3);
    checkOutput("rst_s_ready", {15'd0, s_ready}, 16'd0);
    checkOutput("rst_ge_flag", {15'd0, ge_flag}, 16'd0);
    checkOutput("rst_alarm", {15'd0, alarm}, 16'd0);
    checkOutput("rst_rise", {15'd0, alarm_rise}, 16'd0);
    checkOutput("rst_fall", {15'd0, alarm_fall}, 16'd0);
    checkOutput("rst_max", {8'd0, max_val}, 16'd0);
    checkOutput("rst_cnt", sample_cnt, 16'd0);
    reset = 1'b0;
    idle(1);

    // Debounced rise: one low sample then four at the threshold
    for (int i = 0; i < 5; i++) begin
      applyStimulus(rise_data[i], rise_ge[i]);
      checkOutput("rise_alarm_early", {15'd0, alarm}, 16'd0);
    end
    idle(1);
    checkOutput("rise_alarm", {15'd0, alarm}, 16'd1);
    checkOutput("rise_pulse", {15'd0, alarm_rise}, 16'd1);
    idle(1);
    checkOutput("rise_alarm_hold", {15'd0, alarm}, 16'd1);
    checkOutput("rise_pulse_end", {15'd0, alarm_rise}, 16'd0);

    // Broken low run followed by four consecutive lows
    for (int i = 0; i < 8; i++) begin
      applyStimulus(fall_data[i], fall_ge[i]);
      checkOutput("fall_alarm_hold", {15'd0, alarm}, 16'd1);
      checkOutput("fall_pulse_early", {15'd0, alarm_fall}, 16'd0);
    end
    idle(1);
    checkOutput("fall_alarm", {15'd0, alarm}, 16'd0);
    checkOutput("fall_pulse", {15'd0, alarm_fall}, 16'd1);
    idle(1);
    checkOutput("fall_pulse_end", {15'd0, alarm_fall}, 16'd0);

    // Threshold write blocks the offered sample for one cycle
    thresh_wr = 1'b1; thresh_in = 8'h20; s_valid = 1'b1; s_data = 8'h30;
    #1;
    checkOutput("wr_s_ready", {15'd0, s_ready}, 16'd0);
    @(posedge clk);
    #1;
    thresh_wr = 1'b0;
    checkOutput("wr_not_accepted", {15'd0, ge_flag}, 16'd0);
    #1;
    checkOutput("wr_s_ready_after", {15'd0, s_ready}, 16'd1);
    exp_q.push_back(1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    idle(2);

    // Statistics: plain clear, max tracking, clear coincident with a sample
    clear_stats = 1'b1;
    idle(1);
    clear_stats = 1'b0;
    checkOutput("clr_max", {8'd0, max_val}, 16'd0);
    checkOutput("clr_cnt", sample_cnt, 16'd0);
    applyStimulus(8'h05, 1'b0);
    applyStimulus(8'hC3, 1'b1);
    applyStimulus(8'h40, 1'b1);
    applyStimulus(8'h12, 1'b0);
    checkOutput("stat_max", {8'd0, max_val}, 16'h00C3);
    checkOutput("stat_cnt", sample_cnt, 16'd3);
    clear_stats = 1'b1;
    idle(1);
    clear_stats = 1'b0;
    checkOutput("clrv_max", {8'd0, max_val}, 16'h0012);
    checkOutput("clrv_cnt", sample_cnt, 16'd1);
    idle(1);
    checkOutput("clrv_cnt_hold", sample_cnt, 16'd1);

    // Idle gaps between qualifying samples keep the run alive
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h50, 1'b1);
      checkOutput("gap_alarm_early", {15'd0, alarm}, 16'd0);
      if (i < 3) idle(3);
    end
    idle(1);
    checkOutput("gap_alarm", {15'd0, alarm}, 16'd1);
    checkOutput("gap_rise", {15'd0, alarm_rise}, 16'd1);

    // Reset in the middle of a falling run
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h10, 1'b0);
    checkOutput("mid_alarm_hold", {15'd0, alarm}, 16'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_s_ready", {15'd0, s_ready}, 16'd0);
    idle(1);
    checkOutput("mid_alarm", {15'd0, alarm}, 16'd0);
    checkOutput("mid_fall", {15'd0, alarm_fall}, 16'd0);
    checkOutput("mid_rise", {15'd0, alarm_rise}, 16'd0);
    checkOutput("mid_ge_flag", {15'd0, ge_flag}, 16'd0);
    checkOutput("mid_max", {8'd0, max_val}, 16'd0);
    checkOutput("mid_cnt", sample_cnt, 16'd0);
    reset = 1'b0;
    idle(1);
    checkOutput("mid_fall_after", {15'd0, alarm_fall}, 16'd0);
    checkOutput("mid_alarm_after", {15'd0, alarm}, 16'd0);
    applyStimulus(8'h7F, 1'b0);
    applyStimulus(8'h80, 1'b1);
    idle(2);

    // Sample counter saturation
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int i = 0; i < 65534; i++) applyStimulus(8'h01, 1'b0);
    idle(2);
    checkOutput("sat_cnt_fffe", sample_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) applyStimulus(8'h01, 1'b0);
    idle(2);
    checkOutput("sat_cnt_ffff", sample_cnt, 16'hFFFF);
    checkOutput("sat_max", {8'd0, max_val}, 16'h0001);
    checkOutput("sat_alarm", {15'd0, alarm}, 16'd0);

    checkOutput("sb_leftover", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ge_threshold_monitor.md
Name: ge_threshold_monitor

Overview:
- Streaming consumer of the 8-bit magnitude comparator; it sits directly downstream of `eight_bit_comp` and uses its G/Q/L outputs.
- Registers an incoming 8-bit sample stream and compares each sample against a programmable threshold.
- Raises a debounced "greater-than-or-equal" alarm through a 4-state hysteresis FSM.
- Also keeps running statistics: the maximum sample seen and a sample count.

Parameters:
- DEBOUNCE, 4, consecutive qualifying samples needed to enter or leave the alarm; legal range 1..15.
- THRESH_RST, 8'h80, threshold value after reset.
- CNT_W, 4, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- thresh_wr  input  1  threshold write strobe.
- thresh_in  input  8  new threshold value.
- clear_stats  input  1  synchronous clear of max_val and sample_cnt.
- s_valid  input  1  sample valid.
- s_data  input  8  sample value, unsigned.
- s_ready  output  1  block can accept a sample this cycle.
- ge_flag  output  1  registered sample is >= threshold (qualified by the internal valid).
- alarm  output  1  debounced alarm level.
- alarm_rise  output  1  one-cycle pulse on the alarm 0->1 transition.
- alarm_fall  output  1  one-cycle pulse on the alarm 1->0 transition.
- max_val  output  8  largest sample accepted since reset or clear.
- sample_cnt  output  16  number of accepted samples; saturates at 16'hFFFF.

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous, active-high, and overrides everything.
  - Reset values: thresh_q=THRESH_RST, valid_q=0, state=BELOW, cnt=0, alarm=0, alarm_rise=0, alarm_fall=0, ge_flag=0, max_val=0, sample_cnt=0.
  - s_ready is 0 while reset is high.
- Handshake:
  - s_ready = ~reset & ~thresh_wr.
  - A transfer occurs when s_valid & s_ready; there is no other backpressure.
  - When thresh_wr=1, the sample offered that cycle is not accepted; the source must hold it.
- Threshold update:
  - thresh_q <= thresh_in on the edge where thresh_wr=1.
  - A sample already sitting in sample_q during that cycle is compared against the old threshold.
- Stage 1, input register:
  - On a transfer, sample_q <= s_data and valid_q <= 1; otherwise valid_q <= 0.
- Comparison (combinational on stage-1 outputs):
  - Comparator A evaluates sample_q against thresh_q: ge = G | Q.
  - Comparator B evaluates sample_q against max_val: gt = G.
  - ge_flag = valid_q & ge.
  - Latency: a sample accepted at edge E0 shows on ge_flag immediately after E0.
- Stage 2, FSM (updates only when valid_q=1; otherwise it holds):
  - BELOW: ge -> RISING with cnt=1, or straight to ALARM if DEBOUNCE==1; lt -> stay, cnt=0.
  - RISING: ge & cnt==DEBOUNCE-1 -> ALARM with cnt=0; ge otherwise -> cnt++; lt -> BELOW with cnt=0.
  - ALARM: lt -> FALLING with cnt=1, or straight to BELOW if DEBOUNCE==1; ge -> stay.
  - FALLING: lt & cnt==DEBOUNCE-1 -> BELOW with cnt=0; lt otherwise -> cnt++; ge -> ALARM with cnt=0.
  - Cycles with valid_q=0 (gaps) neither break nor advance a run.
- FSM outputs (registered):
  - alarm = state ∈ {ALARM, FALLING}.
  - alarm_rise/alarm_fall pulse high on the same cycle alarm first changes, for exactly one cycle.
  - End-to-end: the DEBOUNCE-th qualifying sample, accepted at edge E0, sets alarm at E1.
- Statistics:
  - When valid_q=1: sample_cnt increments, holding at 16'hFFFF; if gt, max_val <= sample_q.
  - clear_stats & valid_q together: max_val <= sample_q and sample_cnt <= 1, so the coincident sample is counted first.
  - clear_stats alone: both statistics go to 0.
  - clear_stats does not affect the FSM or thresh_q.
- Reset mid-run: the debounce run is discarded, alarm drops without generating an alarm_fall pulse, and the in-flight sample is lost.

Decomposition:
- Shared package holds:
  - state encoding constants: BELOW=2'd0, RISING=2'd1, ALARM=2'd2, FALLING=2'd3;
  - DEBOUNCE and THRESH_RST defaults;
  - the sample_cnt saturation constant.
- Sub-module: the existing `eight_bit_comp`, instantiated twice (threshold compare and max compare). No new sub-module.

Test Plan:
- Reset, then stream 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80 with THRESH_RST=8'h80 and DEBOUNCE=4 -> ge_flag=0,1,1,1,1; alarm and alarm_rise go high one cycle after the 5th sample's ge_flag; alarm_rise is high for exactly one cycle.
- While in ALARM, stream 8'h10 x3, then 8'hFF, then 8'h10 x4 -> alarm stays 1 throughout the broken run; alarm_fall pulses only after the 4th consecutive low sample.
- Assert thresh_wr with thresh_in=8'h20 while s_valid=1 and s_data=8'h30 -> s_ready=0 and the sample is not accepted; on the next cycle it is accepted and ge_flag=1 against 8'h20.
- Stream 8'h05, 8'hC3, 8'h40, then clear_stats coincident with valid_q on 8'h12 -> max_val=8'hC3 before the clear, then max_val=8'h12 with sample_cnt=1.
- Insert idle gaps of 3 cycles between 4 qualifying samples -> alarm still asserts and cnt holds across the gaps. Separately, pulse reset mid-run -> all outputs return to their reset values with no alarm_fall pulse.
- Force sample_cnt to 16'hFFFE and stream 3 samples -> it reaches 16'hFFFF and stays there.
